sevenseg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for a bank of common-anode seven-segment digits in the io_dev subsystem. It holds CPU-written hex nibbles, one per digit, and sequences a single shared sevenseg_dec instance across the digits. It also drives the active-low anode selects and registered active-low segment lines. A per-slot blanking interval suppresses ghosting between digits.

---
 rtl/sevenseg_scan_ctrl_if.sv | 19 +
 rtl/sevenseg_scan_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_ctrl_if.sv
// Register access bus for the seven-segment scan controller: single-cycle
// write strobe plus a combinational read port.
interface sevenseg_scan_ctrl_if;
   logic        wr_en;
   logic        wr_sel;
   logic [31:0] wr_data;
   logic        rd_sel;
   logic [31:0] rd_data;

   modport master (
      output wr_en, wr_sel, wr_data, rd_sel,
      input  rd_data
   );

   modport slave (
      input  wr_en, wr_sel, wr_data, rd_sel,
      output rd_data
   );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits,
// sharing one external hex decoder across all digit slots.
module sevenseg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DIGIT_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sevenseg_scan_ctrl_if.slave   bus,
   output logic [3:0]            dec_bin,
   input  logic [6:0]            dec_seg,
   output logic [NUM_DIGITS-1:0] an_n,
   output logic [6:0]            seg_n,
   output logic [2:0]            digit_idx
);

   localparam int DW   = 4 * NUM_DIGITS;
   localparam int CTW  = NUM_DIGITS + 1;
   localparam int CNTW = $clog2(DIGIT_CYCLES);

   localparam logic [CNTW-1:0] BLANK_LAST = CNTW'(BLANK_CYCLES - 1);
   localparam logic [CNTW-1:0] DIGIT_LAST = CNTW'(DIGIT_CYCLES - 1);
   localparam logic [2:0]      IDX_LAST   = 3'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_e;

   logic [DW-1:0]         data_q,  data_d;
   logic [CTW-1:0]        ctrl_q,  ctrl_d;
   state_e                state_q, state_d;
   logic [CNTW-1:0]       cnt_q,   cnt_d;
   logic [2:0]            idx_q,   idx_d;
   logic [NUM_DIGITS-1:0] an_n_q,  an_n_d;
   logic [6:0]            seg_n_q, seg_n_d;

   logic [NUM_DIGITS-1:0] onehot_s;
   logic                  mask_s;

   // Register writes; ignored upper bits simply fall off the slice.
   always_comb begin
      data_d = data_q;
      ctrl_d = ctrl_q;
      if (bus.wr_en) begin
         if (bus.wr_sel) begin
            ctrl_d = bus.wr_data[CTW-1:0];
         end else begin
            data_d = bus.wr_data[DW-1:0];
         end
      end else begin
         data_d = data_q;
      end
   end

   // Register readback, zero-extended.
   always_comb begin
      if (bus.rd_sel) begin
         bus.rd_data = 32'(ctrl_q);
      end else begin
         bus.rd_data = 32'(data_q);
      end
   end

   // Slot sequencer: blank phase then drive phase per digit, restart on disable.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      if (!ctrl_q[0]) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = 3'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               idx_d   = 3'd0;
            end
            ST_BLANK: begin
               cnt_d = cnt_q + CNTW'(1);
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_DRIVE;
               end else begin
                  state_d = ST_BLANK;
               end
            end
            ST_DRIVE: begin
               if (cnt_q == DIGIT_LAST) begin
                  state_d = ST_BLANK;
                  cnt_d   = '0;
                  idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
               end else begin
                  cnt_d = cnt_q + CNTW'(1);
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = 3'd0;
            end
         endcase
      end
   end

   // Current-digit selection: nibble to the shared decoder, anode, mask bit.
   always_comb begin
      dec_bin  = 4'd0;
      mask_s   = 1'b0;
      onehot_s = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == 3'(i)) begin
            dec_bin     = data_q[4*i +: 4];
            mask_s      = ctrl_q[i+1];
            onehot_s[i] = 1'b1;
         end else begin
            onehot_s[i] = 1'b0;
         end
      end
   end

   // Output drive: lit only in the drive phase of an enabled digit.
   always_comb begin
      an_n_d  = '1;
      seg_n_d = 7'h7F;
      if ((state_q == ST_DRIVE) && mask_s) begin
         an_n_d  = ~onehot_s;
         seg_n_d = dec_seg;
      end else begin
         an_n_d  = '1;
         seg_n_d = 7'h7F;
      end
   end

   // State, registers and registered display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         ctrl_q  <= '0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         an_n_q  <= '1;
         seg_n_q <= 7'h7F;
      end else begin
         data_q  <= data_d;
         ctrl_q  <= ctrl_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         an_n_q  <= an_n_d;
         seg_n_q <= seg_n_d;
      end
   end

   assign an_n      = an_n_q;
   assign seg_n     = seg_n_q;
   assign digit_idx = idx_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench: a position-based scan model predicts every cycle's outputs,
// a monitor compares them one edge later.
module tb_sevenseg_scan_ctrl;
   localparam int N = 4;
   localparam int D = 8;
   localparam int B = 2;
   localparam int P = N * D;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   dec_bin;
   logic [6:0]   dec_seg;
   logic [N-1:0] an_n;
   logic [6:0]   seg_n;
   logic [2:0]   digit_idx;

   sevenseg_scan_ctrl_if bus ();

   sevenseg_scan_ctrl #(.NUM_DIGITS(N), .DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .dec_bin(dec_bin), .dec_seg(dec_seg),
      .an_n(an_n), .seg_n(seg_n), .digit_idx(digit_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_lut(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  4'hF: return 7'h0E;
         default: return 7'h7F;
      endcase
   endfunction

   // External shared decoder
   assign dec_seg = seg_lut(dec_bin);

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      logic [2:0]  idx;
      logic [3:0]  bin;
      logic [31:0] rd;
   } exp_t;

   exp_t q[$];

   int total = 0;
   int bad   = 0;

   // Model: scan position t = idx*D + cnt while running
   int          m_t   = 0;
   bit          m_run = 1'b0;
   logic [15:0] m_data = 16'h0;
   logic [4:0]  m_ctrl = 5'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_t = 0; m_run = 1'b0; m_data = 16'h0; m_ctrl = 5'h0;
   endtask

   task automatic cycle(input bit we, input bit ws, input logic [31:0] wd, input bit rs);
      exp_t e;
      int   slot;
      int   ph;
      bit   en_now;
      @(negedge clk);
      bus.wr_en = we; bus.wr_sel = ws; bus.wr_data = wd; bus.rd_sel = rs;
      slot = m_t / D;
      ph   = m_t % D;
      if (m_run && ph >= B && m_ctrl[slot+1]) begin
         e.an  = ~(4'b0001 << slot);
         e.seg = seg_lut(m_data[slot*4 +: 4]);
      end else begin
         e.an  = 4'hF;
         e.seg = 7'h7F;
      end
      en_now = m_ctrl[0];
      m_t    = (en_now && m_run) ? (m_t + 1) % P : 0;
      m_run  = en_now;
      if (we) begin
         if (ws) m_ctrl = wd[4:0];
         else    m_data = wd[15:0];
      end
      e.idx = 3'(m_t / D);
      e.bin = m_data[(m_t / D)*4 +: 4];
      e.rd  = rs ? {27'h0, m_ctrl} : {16'h0, m_data};
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 32'h0, 1'($urandom_range(0, 1)));
   endtask

   task automatic wait_pos(input int target, input string name);
      int k = 0;
      while (m_t != target && k < 200) begin
         idle(1);
         k++;
      end
      check(name, 32'(m_t), 32'(target));
   endtask

   // Monitor: compare DUT against scoreboard one delta after each edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("an_n",      32'(an_n),      32'(e.an));
            check("seg_n",     32'(seg_n),     32'(e.seg));
            check("digit_idx", 32'(digit_idx), 32'(e.idx));
            check("dec_bin",   32'(dec_bin),   32'(e.bin));
            check("rd_data",   bus.rd_data,    e.rd);
            check("an_onehot", 32'($countones(~an_n) <= 1), 32'd1);
         end
      end
   end

   initial begin
      logic [31:0] wd;
      bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_data = 32'h0; bus.rd_sel = 1'b0;

      // Reset state
      #12;
      check("rst_an",  32'(an_n),      32'hF);
      check("rst_seg", 32'(seg_n),     32'h7F);
      check("rst_idx", 32'(digit_idx), 32'h0);
      check("rst_bin", 32'(dec_bin),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Scenario 1: no writes, stays dark
      idle(40);

      // Scenario 2: all digits enabled
      cycle(1'b1, 1'b0, 32'h0000_4321, 1'b0);
      cycle(1'b1, 1'b1, 32'h0000_001F, 1'b1);
      idle(70);

      // Scenario 3: only digits 1 and 3 enabled
      cycle(1'b1, 1'b1, 32'h0000_0015, 1'b1);
      cycle(1'b1, 1'b0, 32'hABCD_FEDC, 1'b0);
      idle(70);

      // Scenario 4: rewrite nibble 0 mid-drive of digit 0
      cycle(1'b1, 1'b1, 32'h0000_001F, 1'b0);
      cycle(1'b1, 1'b0, 32'h0000_FED8, 1'b0);
      wait_pos(B + 1, "s4_align");
      cycle(1'b1, 1'b0, 32'h0000_FEDA, 1'b0);
      idle(10);

      // Scenario 5: disable mid-drive of digit 2, then re-enable
      wait_pos(2*D + B + 2, "s5_align");
      cycle(1'b1, 1'b1, 32'h0000_001E, 1'b1);
      idle(6);
      cycle(1'b1, 1'b1, 32'h0000_001F, 1'b1);
      idle(20);

      // Scenario 6: asynchronous reset between edges
      wait_pos(D + B + 3, "s6_align");
      idle(1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_an",  32'(an_n),      32'hF);
      check("arst_seg", 32'(seg_n),     32'h7F);
      check("arst_idx", 32'(digit_idx), 32'h0);
      bus.rd_sel = 1'b0;
      #1;
      check("arst_rd_data", bus.rd_data, 32'h0);
      bus.rd_sel = 1'b1;
      #1;
      check("arst_rd_ctrl", bus.rd_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      idle(5);

      // Randomized traffic
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 19) == 0) begin
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 9) < 8) wd[0] = 1'b1;
               cycle(1'b1, 1'b1, wd, 1'($urandom_range(0, 1)));
            end else begin
               cycle(1'b1, 1'b0, wd, 1'($urandom_range(0, 1)));
            end
         end else begin
            idle(1);
         end
      end
      idle(1);
      @(posedge clk);
      #2;
      check("drain", 32'(q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
